// File: rtl/rv32_mem_pkg.sv
// Shared load/store encodings for the data-memory responder and the control decoder.
package rv32_mem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRESP = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Access size derived from a store strobe or a load format code
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Store-size codes (req_wstrb)
    localparam logic [3:0] WSTRB_SB = 4'b0001;
    localparam logic [3:0] WSTRB_SH = 4'b0011;
    localparam logic [3:0] WSTRB_SW = 4'b1111;

    // Load-format codes (req_lfmt); bit 3 selects zero-extension
    localparam logic [3:0] LFMT_LB  = 4'b0001;
    localparam logic [3:0] LFMT_LH  = 4'b0011;
    localparam logic [3:0] LFMT_LW  = 4'b1111;
    localparam logic [3:0] LFMT_LBU = 4'b1001;
    localparam logic [3:0] LFMT_LHU = 4'b1011;

    // Move store strobes to their byte lanes; lanes past byte 3 fall off
    function automatic logic [3:0] lane_shift(input logic [3:0] strb, input logic [1:0] off);
        return strb << off;
    endfunction

    function automatic size_e store_size(input logic [3:0] strb);
        case (strb)
            WSTRB_SB: return SZ_BYTE;
            WSTRB_SH: return SZ_HALF;
            default:  return SZ_WORD;
        endcase
    endfunction

    // Unrecognised load formats behave as LW
    function automatic size_e load_size(input logic [3:0] lfmt);
        case (lfmt)
            LFMT_LB, LFMT_LBU: return SZ_BYTE;
            LFMT_LH, LFMT_LHU: return SZ_HALF;
            default:           return SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Shift the addressed lane down (upper bytes zero-filled) then size/extend
    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic [1:0]  off,
                                                 input logic [3:0]  lfmt);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (load_size(lfmt))
            SZ_BYTE: return lfmt[3] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: return lfmt[3] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised data RAM with per-byte-lane write enables and a registered read port.
module dmem_byte_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane writes and registered read; contents are never reset
    always_ff @(posedge clk_i) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (be_i[lane]) begin
                mem_q[addr_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder of the core's load/store port: byte-strobed stores, RV32I load
// extraction, one outstanding request. Build option ALIGN_TRAP_EN turns misaligned
// half/word accesses into error responses instead of truncated lane accesses.
module data_mem_responder
    import rv32_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [3:0]  req_lfmt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    state_e      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  lfmt_q, lfmt_d;
    logic        trap_q, trap_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        accept_c;
    logic        trap_now_c;
    logic [3:0]  ram_be_c;
    logic [31:0] ram_wdata_c;
    logic [31:0] ram_rdata;
    logic        unused_addr_hi;

    // Addresses alias above the word-index bits
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept_c  = req_valid && req_ready;

    // Misalignment check on the request being accepted
`ifdef ALIGN_TRAP_EN
    assign trap_now_c = misaligned(req_we ? store_size(req_wstrb) : load_size(req_lfmt),
                                   req_addr[1:0]);
`else
    assign trap_now_c = 1'b0;
`endif

    // Store lanes commit on the accept edge; loads read the RAM on the same edge
    assign ram_be_c    = (accept_c && req_we && !trap_now_c)
                         ? lane_shift(req_wstrb, req_addr[1:0]) : 4'b0000;
    assign ram_wdata_c = req_wdata << {req_addr[1:0], 3'b000};

    dmem_byte_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk_i  (clk),
        .addr_i (req_addr[AW+1:2]),
        .be_i   (ram_be_c),
        .wdata_i(ram_wdata_c),
        .re_i   (accept_c && !req_we),
        .rdata_o(ram_rdata)
    );

    // State and response registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            off_q       <= 2'b00;
            lfmt_q      <= 4'b0000;
            trap_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            lfmt_q      <= lfmt_d;
            trap_q      <= trap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and response formation
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        lfmt_d      = lfmt_q;
        trap_d      = trap_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    off_d  = req_addr[1:0];
                    lfmt_d = req_lfmt;
                    trap_d = trap_now_c;
                    if (req_we) begin
                        state_d     = ST_WRESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                        rsp_err_d   = trap_now_c;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = trap_q;
                rsp_rdata_d = trap_q ? 32'h0 : load_extract(ram_rdata, off_q, lfmt_q);
            end
            ST_WRESP, ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized
// traffic against a byte-level memory model. Honours ALIGN_TRAP_EN like the RTL.
module tb_data_mem_responder;

`ifdef ALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wstrb = 4'h0;
    logic [3:0]  req_lfmt = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [1024];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .AW(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_lfmt(req_lfmt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    // ---------------- reference model (byte view of memory) ----------------
    function automatic int strb_bytes(input logic [3:0] s);
        if (s == 4'b0001) return 1;
        if (s == 4'b0011) return 2;
        return 4;
    endfunction

    function automatic int lfmt_bytes(input logic [3:0] f);
        if (f == 4'b0001 || f == 4'b1001) return 1;
        if (f == 4'b0011 || f == 4'b1011) return 2;
        return 4;
    endfunction

    function automatic bit is_mis(input int n, input int off);
        if (n == 2) return (off % 2) != 0;
        if (n == 4) return off != 0;
        return 1'b0;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, output logic err);
        int n, off, idx;
        n = strb_bytes(strb);
        off = int'(addr % 4);
        idx = int'((addr / 4) % 1024);
        err = 1'b0;
        if (TRAP && is_mis(n, off)) begin
            err = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (off + k < 4) mem_m[idx][(off+k)*8 +: 8] = wdata[k*8 +: 8];
        end
    endtask

    task automatic model_load(input logic [31:0] addr, input logic [3:0] lfmt,
                              output logic [31:0] rd, output logic err);
        int n, off, idx;
        n = lfmt_bytes(lfmt);
        off = int'(addr % 4);
        idx = int'((addr / 4) % 1024);
        rd = 32'h0;
        err = 1'b0;
        if (TRAP && is_mis(n, off)) begin
            err = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (off + k < 4) rd[k*8 +: 8] = mem_m[idx][(off+k)*8 +: 8];
        end
        if (n < 4 && !lfmt[3] && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
    endtask

    // ---------------- driver: one full transaction, bounded wait ----------------
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [3:0] lfmt,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_wstrb = wstrb; req_lfmt = lfmt; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_wstrb = 4'($urandom); req_lfmt = 4'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready_in_rst got %b exp 0", req_ready); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready_after got %b exp 1", req_ready); end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 4'h0, rd, er, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL sw_latency got %0d exp 1", lat); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_rsp got %h/%b exp 0/0", rd, er); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 4'b1111, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_word got %h exp DEADBEEF", rd); end
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h10, 32'h11223344, 4'b1111, 4'h0, rd, er, lat);
        do_req(1'b1, 32'h13, 32'h00000080, 4'b0001, 4'h0, rd, er, lat);
        do_req(1'b0, 32'h13, 32'h0, 4'h0, 4'b0001, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sign got %h exp FFFFFF80", rd); end
        do_req(1'b0, 32'h13, 32'h0, 4'h0, 4'b1001, rd, er, lat);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_zero got %h exp 00000080", rd); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'h80223344) begin errors++; $display("FAIL sb_lanes got %h exp 80223344", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h20, 32'hAAAABBBB, 4'b1111, 4'h0, rd, er, lat);
        do_req(1'b1, 32'h22, 32'h00008001, 4'b0011, 4'h0, rd, er, lat);
        do_req(1'b0, 32'h22, 32'h0, 4'h0, 4'b0011, rd, er, lat);
        checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_sign got %h exp FFFF8001", rd); end
        do_req(1'b0, 32'h22, 32'h0, 4'h0, 4'b1011, rd, er, lat);
        checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_zero got %h exp 00008001", rd); end
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'h8001BBBB) begin errors++; $display("FAIL sh_low_kept got %h exp 8001BBBB", rd); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h40, 32'h12345678, 4'b1111, 4'h0, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_lfmt = 4'b1111; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL bp_first got %b/%h exp 1/12345678", rsp_valid, rsp_rdata); end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc %0d got v%b d%h r%b exp v1 d12345678 r0", i, rsp_valid, rsp_rdata, req_ready);
            end
        end
        @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", rsp_valid); end
        do_req(1'b0, 32'h40, 32'h0, 4'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL bp_store_ignored got %h exp 12345678", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h50, 32'hCAFEF00D, 4'b1111, 4'h0, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h50; req_lfmt = 4'b1111; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_state got v%b r%b exp v0 r0", rsp_valid, req_ready); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", req_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_stale got %b exp 0", rsp_valid); end
        do_req(1'b0, 32'h50, 32'h0, 4'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rstmid_data got %h exp CAFEF00D", rd); end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd; logic er; int lat;
        logic [31:0] exp_w, exp_lh, exp_lb, exp_lw;
        logic        exp_e;
        exp_e  = TRAP;
        exp_w  = TRAP ? 32'h11223344 : 32'hBBCCDD44;
        exp_lh = TRAP ? 32'h0 : 32'h000000BB;
        exp_lb = TRAP ? 32'h00000011 : 32'hFFFFFFBB;
        exp_lw = TRAP ? 32'h0 : 32'h00BBCCDD;
        do_req(1'b1, 32'h30, 32'h11223344, 4'b1111, 4'h0, rd, er, lat);
        do_req(1'b1, 32'h31, 32'hAABBCCDD, 4'b1111, 4'h0, rd, er, lat);
        checks++; if (er !== exp_e || rd !== 32'h0 || lat !== 1) begin errors++; $display("FAIL mis_sw_rsp got e%b d%h l%0d exp e%b d0 l1", er, rd, lat, exp_e); end
        do_req(1'b0, 32'h30, 32'h0, 4'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== exp_w || er !== 1'b0) begin errors++; $display("FAIL mis_sw_word got %h/%b exp %h/0", rd, er, exp_w); end
        do_req(1'b0, 32'h33, 32'h0, 4'h0, 4'b0011, rd, er, lat);
        checks++; if (rd !== exp_lh || er !== exp_e || lat !== 2) begin errors++; $display("FAIL mis_lh got %h/%b l%0d exp %h/%b l2", rd, er, lat, exp_lh, exp_e); end
        do_req(1'b0, 32'h31, 32'h0, 4'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== exp_lw || er !== exp_e) begin errors++; $display("FAIL mis_lw got %h/%b exp %h/%b", rd, er, exp_lw, exp_e); end
        do_req(1'b0, 32'h33, 32'h0, 4'h0, 4'b0001, rd, er, lat);
        checks++; if (rd !== exp_lb || er !== 1'b0) begin errors++; $display("FAIL mis_lb_ok got %h/%b exp %h/0", rd, er, exp_lb); end
    endtask

    task automatic test_alias;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h0000_1010, 32'h5A5AA5A5, 4'b1111, 4'h0, rd, er, lat);
        do_req(1'b0, 32'hFFFF_F010, 32'h0, 4'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'h5A5AA5A5) begin errors++; $display("FAIL alias_wrap got %h exp 5A5AA5A5", rd); end
    endtask

    task automatic test_random;
        logic [31:0] rd, exp_rd, addr, wdata;
        logic        er, exp_er, we;
        logic [3:0]  strb, lfmt;
        logic [3:0]  strbs [3];
        logic [3:0]  lfmts [5];
        int          lat, exp_lat;
        strbs = '{4'b0001, 4'b0011, 4'b1111};
        lfmts = '{4'b0001, 4'b0011, 4'b1111, 4'b1001, 4'b1011};
        for (int w = 0; w < 64; w++) begin
            wdata = $urandom;
            model_store(32'(w * 4), wdata, 4'b1111, exp_er);
            do_req(1'b1, 32'(w * 4), wdata, 4'b1111, 4'h0, rd, er, lat);
        end
        for (int i = 0; i < 200; i++) begin
            we    = 1'($urandom);
            addr  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            wdata = $urandom;
            strb  = strbs[$urandom_range(0, 2)];
            lfmt  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : lfmts[$urandom_range(0, 4)];
            if (we) begin
                model_store(addr, wdata, strb, exp_er);
                exp_rd = 32'h0; exp_lat = 1;
            end else begin
                model_load(addr, lfmt, exp_rd, exp_er);
                exp_lat = 2;
            end
            do_req(we, addr, wdata, strb, lfmt, rd, er, lat);
            checks++; if (rd !== exp_rd || er !== exp_er || lat !== exp_lat) begin
                errors++;
                $display("FAIL rand_op %0d we%b a%h s%h f%h got d%h e%b l%0d exp d%h e%b l%0d",
                         i, we, addr, strb, lfmt, rd, er, lat, exp_rd, exp_er, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_backpressure();
        test_reset_mid();
        test_misaligned();
        test_alias();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired exp completion before 400000");
        $fatal(1);
    end

endmodule
